// File: rtl/tetris_pkg.sv
// Shared board constants, command encoding and payload layout for the tetris command ports.
package tetris_pkg;

   localparam int unsigned BOARD_ROWS = 20;
   localparam int unsigned BOARD_COLS = 10;

   localparam logic [1:0] OP_WRITE_CELL  = 2'd0;
   localparam logic [1:0] OP_CLEAR_BOARD = 2'd1;

   // Bit positions of the command fields inside a 32-bit register write
   localparam int unsigned OP_MSB    = 31;
   localparam int unsigned OP_LSB    = 30;
   localparam int unsigned COLOR_MSB = 15;
   localparam int unsigned COLOR_LSB = 12;
   localparam int unsigned ROW_MSB   = 9;
   localparam int unsigned ROW_LSB   = 5;
   localparam int unsigned COL_MSB   = 3;
   localparam int unsigned COL_LSB   = 0;

   typedef struct packed {
      logic [1:0] op;
      logic [4:0] row;
      logic [3:0] col;
      logic [3:0] color;
   } cmd_t;

   localparam int unsigned CMD_W = $bits(cmd_t);

endpackage

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with registered pointers and occupancy count.
module sync_fifo #(
   parameter int unsigned WIDTH = 15,
   parameter int unsigned DEPTH = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     push,
   input  logic [WIDTH-1:0]         push_data,
   input  logic                     pop,
   output logic [WIDTH-1:0]         head,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             pop_fire;
   logic             push_fire;

   assign empty     = (count == '0);
   assign full      = (count == CW'(DEPTH));
   assign pop_fire  = pop && !empty;
   // A full FIFO still accepts a push when the head leaves in the same cycle
   assign push_fire = push && (!full || pop_fire);
   assign head      = mem[rd_ptr];

   // Pointer and occupancy tracking; pointers wrap naturally at the power-of-2 depth
   always_ff @(posedge clock) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push_fire) wr_ptr <= wr_ptr + AW'(1);
         if (pop_fire)  rd_ptr <= rd_ptr + AW'(1);
         case ({push_fire, pop_fire})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   // Storage array; contents are don't-care until written, so no reset
   always_ff @(posedge clock) begin
      if (push_fire && !reset) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/regfile_cmd_port.sv
// Snoops register-file writes to SNOOP_REG, decodes them into board commands and queues them.
module regfile_cmd_port
   import tetris_pkg::*;
#(
   parameter int unsigned SNOOP_REG  = 28,
   parameter int unsigned DEPTH      = 8,
   parameter int unsigned BOARD_ROWS = tetris_pkg::BOARD_ROWS,
   parameter int unsigned BOARD_COLS = tetris_pkg::BOARD_COLS
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     wr_en,
   input  logic [4:0]               wr_reg,
   input  logic [31:0]              wr_data,
   output logic                     cmd_valid,
   input  logic                     cmd_ready,
   output logic [1:0]               cmd_op,
   output logic [4:0]               cmd_row,
   output logic [3:0]               cmd_col,
   output logic [3:0]               cmd_color,
   output logic [$clog2(DEPTH):0]   fifo_count,
   output logic                     overflow,
   output logic                     bad_cmd,
   input  logic                     err_clr
);

   logic capture;
   cmd_t raw;
   cmd_t decoded;
   logic cmd_ok;
   logic push_req;
   logic bad_set;
   logic ovf_set;
   logic pop_fire;
   logic fifo_full;
   logic fifo_empty;
   cmd_t head;
   logic unused_bits;

   // Register index 0 is hard-wired zero on the CPU, so it never captures
   assign capture = wr_en && (wr_reg == 5'(SNOOP_REG)) && (wr_reg != 5'd0);

   assign raw.op    = wr_data[OP_MSB:OP_LSB];
   assign raw.row   = wr_data[ROW_MSB:ROW_LSB];
   assign raw.col   = wr_data[COL_MSB:COL_LSB];
   assign raw.color = wr_data[COLOR_MSB:COLOR_LSB];

   assign unused_bits = ^{wr_data[29:16], wr_data[11:10], wr_data[4]};

   // Validate the opcode and coordinates; clear-board carries zeroed fields
   always_comb begin
      cmd_ok  = 1'b0;
      decoded = '0;
      case (raw.op)
         OP_WRITE_CELL: begin
            cmd_ok  = (32'(raw.row) < BOARD_ROWS) && (32'(raw.col) < BOARD_COLS);
            decoded = raw;
         end
         OP_CLEAR_BOARD: begin
            cmd_ok     = 1'b1;
            decoded.op = OP_CLEAR_BOARD;
         end
         default: cmd_ok = 1'b0;
      endcase
   end

   assign push_req = capture && cmd_ok;
   assign bad_set  = capture && !cmd_ok;
   assign pop_fire = cmd_valid && cmd_ready;
   assign ovf_set  = push_req && fifo_full && !pop_fire;

   sync_fifo #(
      .WIDTH (CMD_W),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clock     (clock),
      .reset     (reset),
      .push      (push_req),
      .push_data (decoded),
      .pop       (cmd_ready),
      .head      (head),
      .count     (fifo_count),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   assign cmd_valid = !fifo_empty;
   assign cmd_op    = cmd_valid ? head.op    : 2'd0;
   assign cmd_row   = cmd_valid ? head.row   : 5'd0;
   assign cmd_col   = cmd_valid ? head.col   : 4'd0;
   assign cmd_color = cmd_valid ? head.color : 4'd0;

   // Sticky error flags; a new error in the clear cycle keeps the flag set
   always_ff @(posedge clock) begin
      if (reset) begin
         overflow <= 1'b0;
         bad_cmd  <= 1'b0;
      end else begin
         if (ovf_set)      overflow <= 1'b1;
         else if (err_clr) overflow <= 1'b0;
         if (bad_set)      bad_cmd  <= 1'b1;
         else if (err_clr) bad_cmd  <= 1'b0;
      end
   end

endmodule
